// File: rtl/onehot_pulse_decoder.sv
// Sequential 3-to-8 decoder: accepts a binary code over valid/ready and drives its one-hot line for PULSE_LEN cycles.
// Define DECODER_STICKY_EN to build the sticky bitmap of every line driven since the last clear.
module onehot_pulse_decoder #(
  parameter int W         = 3,
  parameter int N_OUT     = 8,
  parameter int PULSE_LEN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_code,
  output logic             in_ready,
  output logic             out_valid,
  output logic [N_OUT-1:0] out_onehot,
  input  logic             clr_sticky,
  output logic [N_OUT-1:0] sticky
);

  typedef enum logic {IDLE, DRIVE} state_t;

  localparam logic [7:0] RELOAD = 8'(PULSE_LEN - 1);

  if (N_OUT != 2**W) begin : g_bad_n_out
    $error("onehot_pulse_decoder: N_OUT must equal 2**W");
  end
  if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse_len
    $error("onehot_pulse_decoder: PULSE_LEN must be in 1..255");
  end

  state_t           state, next_state;
  logic [7:0]       cnt, next_cnt;
  logic [N_OUT-1:0] next_onehot;
  logic             next_valid;
  logic             accept;
  logic [N_OUT-1:0] decoded;

  assign accept  = in_valid && in_ready;
  assign decoded = {{(N_OUT-1){1'b0}}, 1'b1} << in_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      out_valid  <= 1'b0;
      out_onehot <= '0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      out_valid  <= next_valid;
      out_onehot <= next_onehot;
    end
  end

  // An accept on the last DRIVE cycle reloads in place, giving back-to-back pulses with no idle gap.
  always_comb begin
    next_state  = state;
    next_cnt    = cnt;
    next_valid  = out_valid;
    next_onehot = out_onehot;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state  = DRIVE;
          next_cnt    = RELOAD;
          next_valid  = 1'b1;
          next_onehot = decoded;
        end
      end
      DRIVE: begin
        if (cnt != 8'd0) begin
          next_cnt = cnt - 8'd1;
        end else if (accept) begin
          next_cnt    = RELOAD;
          next_valid  = 1'b1;
          next_onehot = decoded;
        end else begin
          next_state  = IDLE;
          next_valid  = 1'b0;
          next_onehot = '0;
        end
      end
      default: begin
        next_state  = IDLE;
        next_cnt    = 8'd0;
        next_valid  = 1'b0;
        next_onehot = '0;
      end
    endcase
  end

  // Ready is held low throughout reset even though the state already reads IDLE.
  always_comb begin
    in_ready = !rst && ((state == IDLE) || (cnt == 8'd0));
  end

`ifdef DECODER_STICKY_EN
  logic [N_OUT-1:0] sticky_q;

  // The accepted bit survives a simultaneous clear; every other bit is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
    end else if (accept) begin
      sticky_q <= (clr_sticky ? '0 : sticky_q) | decoded;
    end else if (clr_sticky) begin
      sticky_q <= '0;
    end
  end

  assign sticky = sticky_q;
`else
  logic unused_clr_sticky;

  assign unused_clr_sticky = clr_sticky;
  assign sticky            = '0;
`endif

endmodule

// File: doc/onehot_pulse_decoder.md
# onehot_pulse_decoder

- Sequential 3-to-8 decoder, the inverse of the team's 8-to-3 priority encoder.
- Accepts a binary code over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles.
- Optionally records every line ever driven in a sticky bitmap.
- Sits between the encoder/arbiter index path and per-channel grant/enable lines.

## Interface
Parameters:
- W, 3, code width.
- N_OUT, 8, output line count; must equal 2**W.
- PULSE_LEN, 1, cycles each one-hot is held; legal range 1..255.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_code is valid this cycle.
- in_code  input  W  binary index to decode.
- in_ready  output  1  block can accept a code this cycle.
- out_valid  output  1  out_onehot is driving a line.
- out_onehot  output  N_OUT  one-hot decode; all-zero when idle.
- clr_sticky  input  1  synchronous clear of sticky.
- sticky  output  N_OUT  OR of all one-hots driven since last clear.

## Operation
- States:
  - IDLE: no line driven.
  - DRIVE: one line driven; 8-bit down-counter cnt.
- Accept: in_valid && in_ready at a rising edge.
- IDLE:
  - in_ready = 1.
  - On accept: out_onehot <= 1 << in_code, out_valid <= 1, cnt <= PULSE_LEN-1, go to DRIVE.
- DRIVE, cnt != 0: in_ready = 0; cnt decrements; outputs hold.
- DRIVE, cnt == 0 (last cycle):
  - in_ready = 1.
  - On accept: load the new one-hot and reload cnt; stay in DRIVE with no idle gap.
  - Otherwise: out_onehot <= 0, out_valid <= 0, go to IDLE.
- in_ready is combinational: (state==IDLE) || (cnt==0); it does not depend on in_valid.
- in_code is sampled only on accept. Changes to in_code while not accepted have no effect.
- out_onehot always has exactly one bit set when out_valid=1, and is zero when out_valid=0.
- Sticky:
  - On accept, sticky <= (clr_sticky ? 0 : sticky) | (1 << in_code).
  - Set wins over a simultaneous clear for the accepted bit only.
  - clr_sticky without an accept clears sticky to 0.

## Timing
- Reset values:
  - state=IDLE, cnt=0, out_valid=0, out_onehot=0, sticky=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst deasserts.
- Latency: a code accepted at edge t is visible on out_onehot from after edge t until after edge t+PULSE_LEN, i.e. exactly PULSE_LEN cycles.
- Throughput: one code per PULSE_LEN cycles. With PULSE_LEN=1, in_ready is constantly 1 and a new code can be accepted every cycle.
- Reset mid-pulse: outputs clear immediately (asynchronous); the pending pulse is discarded, not resumed.
- cnt wraps never: cnt only reloads on accept and stops at 0.
- sticky updates on the same edge as the accept; it is visible in the same cycle as out_onehot.

## Configuration
- DECODER_STICKY_EN defined: the sticky register and clr_sticky logic are compiled in, as described above.
- DECODER_STICKY_EN undefined: no sticky flops are generated; sticky is tied to 0 and clr_sticky is ignored. All other behaviour is identical.

## Test plan
- Reset: hold rst=1 for 3 cycles with in_valid=1 -> out_onehot=8'h00, out_valid=0, in_ready=0. One cycle after release -> in_ready=1.
- PULSE_LEN=1, codes 0..7 on consecutive cycles -> out_onehot=8'h01,02,04,...,80 on consecutive cycles, in_ready constantly 1. With sticky enabled, sticky=8'hFF at the end.
- PULSE_LEN=4, code 3'b101 -> out_onehot=8'h20 for exactly 4 cycles. in_ready=0 for the first 3 of those cycles, then 1. Code 3'b010 offered on the last cycle -> 8'h04 follows with no zero gap.
- PULSE_LEN=4, in_valid held high with changing in_code during DRIVE -> only codes present on in_ready=1 cycles are decoded; the others are ignored.
- Sticky = 8'h21, clr_sticky=1 together with an accept of code 3'b000 -> sticky=8'h01 next cycle. clr_sticky alone -> sticky=8'h00.
- PULSE_LEN=5, assert rst asynchronously 2 cycles into the pulse -> out_onehot=0 and out_valid=0 immediately. No residual pulse after release.
